// File: rtl/axi_sort_periph.sv
// AXI4-Lite register front end for an external sorting core: stages N elements
// in an input FIFO, streams them into the core, and collects results in an output FIFO.
module axi_sort_periph #(
    parameter int DATA_WIDTH    = 32,
    parameter int LOG_INPUT_NUM = 3,
    parameter int ASCENDING     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [31:0]           s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  core_rst,
    output logic [DATA_WIDTH-1:0] core_din,
    output logic                  core_load,
    output logic                  core_start,
    output logic                  core_ascending,
    input  logic [DATA_WIDTH-1:0] core_dout,
    input  logic                  core_y_valid,
    output logic                  irq
);

    localparam int unsigned   N        = 1 << LOG_INPUT_NUM;
    localparam int            CW       = LOG_INPUT_NUM + 1;
    localparam int            PW       = LOG_INPUT_NUM;
    localparam logic [CW-1:0] FULL_CNT = CW'(N);

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_DIN    = 3'd1;
    localparam logic [2:0] OFF_STATUS = 3'd2;
    localparam logic [2:0] OFF_DOUT   = 3'd3;
    localparam logic [2:0] OFF_COUNT  = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, LOAD, SORT, DRAIN, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] in_mem  [N];
    logic [DATA_WIDTH-1:0] out_mem [N];
    logic [PW-1:0]         in_wr, in_rd, out_wr, out_rd;
    logic [CW-1:0]         in_count, out_count, load_cnt, push_cnt;
    logic                  err, irq_en, soft_pulse, ready_en;
    logic [1:0]            core_rst_cnt;

    logic                  aw_held, w_held, w_any;
    logic [2:0]            aw_off;
    logic [31:0]           w_data;

    logic                  wr_exec, wr_legal, wr_en, ctrl_wr, din_wr;
    logic                  wr_soft, wr_start, start_ok, din_ok, din_drop;
    logic                  rd_exec, dout_rd, status_rd, out_pop, rd_empty;
    logic                  in_push, in_pop, out_push, push_last, busy, done;
    logic [CW-1:0]         out_count_nxt;
    logic [31:0]           rd_data_c;
    logic [1:0]            rd_resp_c;
    logic                  unused_ok;

    assign s_awready      = ready_en & ~aw_held & ~s_bvalid;
    assign s_wready       = ready_en & ~w_held & ~s_bvalid;
    assign s_arready      = ready_en & ~s_rvalid;
    assign core_ascending = (ASCENDING != 0);
    assign busy           = (state == LOAD) || (state == SORT) || (state == DRAIN);
    assign done           = (state == DONE);
    assign irq            = done & irq_en;
    assign unused_ok      = ^{s_awaddr[31:5], s_awaddr[1:0], s_araddr[31:5], s_araddr[1:0], w_data};

    always_comb begin
        wr_exec   = aw_held & w_held;
        wr_legal  = (aw_off == OFF_CTRL) || (aw_off == OFF_DIN);
        wr_en     = wr_exec & wr_legal & w_any;
        ctrl_wr   = wr_en & (aw_off == OFF_CTRL);
        din_wr    = wr_en & (aw_off == OFF_DIN);
        wr_soft   = ctrl_wr & w_data[0];
        wr_start  = ctrl_wr & w_data[1] & ~w_data[0];
        start_ok  = wr_start & (state == IDLE) & (in_count == FULL_CNT) & (out_count == '0);
        din_ok    = din_wr & (state == IDLE) & (in_count != FULL_CNT);
        din_drop  = din_wr & ~din_ok;
        rd_exec   = s_arvalid & s_arready;
        dout_rd   = rd_exec & (s_araddr[4:2] == OFF_DOUT);
        status_rd = rd_exec & (s_araddr[4:2] == OFF_STATUS);
        out_pop   = dout_rd & (out_count != '0) & ~soft_pulse;
        rd_empty  = dout_rd & (out_count == '0);
        in_push   = din_ok & ~soft_pulse;
        in_pop    = (state == LOAD) & (load_cnt != FULL_CNT) & ~soft_pulse;
        out_push  = core_y_valid & ((state == SORT) || (state == DRAIN))
                  & (push_cnt != FULL_CNT) & ~soft_pulse;
        push_last = out_push & (push_cnt == FULL_CNT - CW'(1));
        out_count_nxt = out_count + CW'(out_push) - CW'(out_pop);
    end

    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        case (s_araddr[4:2])
            OFF_STATUS: rd_data_c = {27'b0, err, out_count == '0, in_count == FULL_CNT, done, busy};
            OFF_DOUT:   if (out_count != '0) rd_data_c = 32'(out_mem[out_rd]);
            OFF_COUNT:  rd_data_c = {16'(out_count), 16'(in_count)};
            default:    rd_resp_c = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_push)  in_mem[in_wr]   <= w_data[DATA_WIDTH-1:0];
        if (out_push) out_mem[out_wr] <= core_dout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en     <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_off       <= '0;
            w_data       <= '0;
            w_any        <= 1'b0;
            s_bvalid     <= 1'b0;
            s_bresp      <= '0;
            s_rvalid     <= 1'b0;
            s_rdata      <= '0;
            s_rresp      <= '0;
            state        <= IDLE;
            in_wr        <= '0;
            in_rd        <= '0;
            out_wr       <= '0;
            out_rd       <= '0;
            in_count     <= '0;
            out_count    <= '0;
            load_cnt     <= '0;
            push_cnt     <= '0;
            err          <= 1'b0;
            irq_en       <= 1'b0;
            soft_pulse   <= 1'b0;
            core_rst     <= 1'b1;
            core_rst_cnt <= '0;
            core_din     <= '0;
            core_load    <= 1'b0;
            core_start   <= 1'b0;
        end else begin
            ready_en <= 1'b1;

            if (s_awvalid && s_awready) begin
                aw_held <= 1'b1;
                aw_off  <= s_awaddr[4:2];
            end
            if (s_wvalid && s_wready) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
                w_any  <= |s_wstrb;
            end
            if (wr_exec) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= wr_legal ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end

            if (rd_exec) begin
                s_rvalid <= 1'b1;
                s_rdata  <= rd_data_c;
                s_rresp  <= rd_resp_c;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end

            if (ctrl_wr) irq_en <= w_data[2];
            core_load  <= 1'b0;
            core_start <= 1'b0;
            soft_pulse <= wr_soft;

            // core_rst stays high for the pulse cycle plus one more
            if (soft_pulse) begin
                core_rst     <= 1'b1;
                core_rst_cnt <= 2'd1;
            end else if (core_rst_cnt != '0) begin
                core_rst     <= 1'b1;
                core_rst_cnt <= core_rst_cnt - 2'd1;
            end else begin
                core_rst <= 1'b0;
            end

            if (soft_pulse) begin
                state     <= IDLE;
                in_wr     <= '0;
                in_rd     <= '0;
                out_wr    <= '0;
                out_rd    <= '0;
                in_count  <= '0;
                out_count <= '0;
                load_cnt  <= '0;
                push_cnt  <= '0;
                err       <= 1'b0;
            end else begin
                err <= (err & ~status_rd) | din_drop | (wr_start & ~start_ok) | rd_empty;
                if (in_push) in_wr <= in_wr + PW'(1);
                if (in_pop) begin
                    core_din  <= in_mem[in_rd];
                    core_load <= 1'b1;
                    in_rd     <= in_rd + PW'(1);
                end
                in_count <= in_count + CW'(in_push) - CW'(in_pop);
                if (out_push) out_wr <= out_wr + PW'(1);
                if (out_pop)  out_rd <= out_rd + PW'(1);
                out_count <= out_count_nxt;

                unique case (state)
                    IDLE: if (start_ok) begin
                        state    <= LOAD;
                        load_cnt <= '0;
                    end
                    LOAD: if (load_cnt == FULL_CNT) begin
                        core_start <= 1'b1;
                        push_cnt   <= '0;
                        state      <= SORT;
                    end else begin
                        load_cnt <= load_cnt + CW'(1);
                    end
                    SORT: if (out_push) begin
                        push_cnt <= push_cnt + CW'(1);
                        state    <= push_last ? DONE : DRAIN;
                    end
                    DRAIN: if (out_push) begin
                        push_cnt <= push_cnt + CW'(1);
                        if (push_last) state <= DONE;
                    end
                    DONE: if (out_count_nxt == '0) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_sort_periph.sv
// Directed bench for axi_sort_periph: register table plus hand-written sequences
// for irq, split AW/W handshakes and reset during a sort. Includes a behavioural sort core.
module tb_axi_sort_periph;

    localparam int N = 8;

    localparam int OP_WR   = 0;
    localparam int OP_RD   = 1;
    localparam int OP_IDLE = 2;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_DIN    = 32'h04;
    localparam logic [31:0] A_STATUS = 32'h08;
    localparam logic [31:0] A_DOUT   = 32'h0C;
    localparam logic [31:0] A_COUNT  = 32'h10;

    typedef struct {
        int          op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic        core_rst, core_load, core_start, core_ascending, core_y_valid, irq;
    logic [31:0] core_din, core_dout;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    axi_sort_periph #(.DATA_WIDTH(32), .LOG_INPUT_NUM(3), .ASCENDING(1)) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .core_rst(core_rst), .core_din(core_din), .core_load(core_load),
        .core_start(core_start), .core_ascending(core_ascending),
        .core_dout(core_dout), .core_y_valid(core_y_valid), .irq(irq)
    );

    // Behavioural core: gathers loaded values, sorts on start, replies after a short delay
    initial begin
        logic [31:0] inq[$];
        logic [31:0] outq[$];
        logic [31:0] arr[N];
        logic [31:0] t;
        int delay;
        delay = 0;
        core_y_valid = 1'b0;
        core_dout = '0;
        forever begin
            @(negedge clk);
            core_y_valid = 1'b0;
            if (rst || core_rst) begin
                inq.delete();
                outq.delete();
                delay = 0;
            end else begin
                if (core_load) inq.push_back(core_din);
                if (core_start) begin
                    start_cnt++;
                    for (int unsigned i = 0; i < N; i++) arr[i] = (i < inq.size()) ? inq[i] : '0;
                    for (int unsigned i = 0; i < N; i++)
                        for (int unsigned j = 0; j + 1 < N - i; j++)
                            if ((arr[j] > arr[j+1]) == core_ascending) begin
                                t = arr[j]; arr[j] = arr[j+1]; arr[j+1] = t;
                            end
                    outq.delete();
                    for (int unsigned i = 0; i < N; i++) outq.push_back(arr[i]);
                    inq.delete();
                    delay = 3;
                end else if (delay > 0) begin
                    delay--;
                end else if (outq.size() > 0) begin
                    core_dout = outq.pop_front();
                    core_y_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timed out", name);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs, got;
        aw_done = 0; w_done = 0; got = 0; resp = 2'b11;
        @(posedge clk); #1;
        s_awvalid = 1'b1; s_awaddr = a; s_wvalid = 1'b1; s_wdata = d; s_wstrb = st; s_bready = 1'b1;
        for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
            @(negedge clk);
            aw_hs = s_awvalid & s_awready;
            w_hs  = s_wvalid & s_wready;
            @(posedge clk); #1;
            if (aw_hs) begin aw_done = 1; s_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_wvalid = 1'b0;  end
        end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_bvalid) begin resp = s_bresp; got = 1; end
            @(posedge clk); #1;
        end
        s_bready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (!(aw_done && w_done && got)) timeout("axi_write");
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done, ar_hs, got;
        ar_done = 0; got = 0; d = '1; resp = 2'b11;
        @(posedge clk); #1;
        s_arvalid = 1'b1; s_araddr = a; s_rready = 1'b1;
        for (int n = 0; n < 50 && !ar_done; n++) begin
            @(negedge clk);
            ar_hs = s_arready;
            @(posedge clk); #1;
            if (ar_hs) begin ar_done = 1; s_arvalid = 1'b0; end
        end
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (s_rvalid) begin d = s_rdata; resp = s_rresp; got = 1; end
            @(posedge clk); #1;
        end
        s_rready = 1'b0; s_arvalid = 1'b0;
        if (!(ar_done && got)) timeout("axi_read");
    endtask

    task automatic add(input int op, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, input logic [1:0] rs, input logic [31:0] e);
        vec_t v;
        v.op = op; v.addr = a; v.data = d; v.strb = st; v.resp = rs; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic read_sorted(input string tag, input logic [31:0] e[N], input bit irq_chk);
        logic [31:0] d;
        logic [1:0]  r;
        for (int unsigned i = 0; i < N; i++) begin
            if (irq_chk) chk($sformatf("%s_irq_before_pop%0d", tag, i), 32'(irq), 32'd1);
            axi_read(A_DOUT, d, r);
            chk($sformatf("%s_dout%0d", tag, i), d, e[i]);
        end
        if (irq_chk) begin
            @(negedge clk);
            chk($sformatf("%s_irq_after_last", tag), 32'(irq), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] b1[N];
        logic [31:0] exp2[N];
        logic [31:0] b3[N];
        logic [31:0] exp3[N];
        bit seen;

        rst = 1'b1;
        s_awvalid = 0; s_awaddr = '0; s_wvalid = 0; s_wdata = '0; s_wstrb = '0; s_bready = 0;
        s_arvalid = 0; s_araddr = '0; s_rready = 0;

        b1   = '{32'd5, 32'd3, 32'd7, 32'd1, 32'd8, 32'd2, 32'd6, 32'd4};
        exp2 = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80};
        b3   = '{32'd1000, 32'd3, 32'd500, 32'd77, 32'd2, 32'd900, 32'd64, 32'd15};
        exp3 = '{32'd2, 32'd3, 32'd15, 32'd64, 32'd77, 32'd500, 32'd900, 32'd1000};

        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h08);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0);
        for (int unsigned i = 0; i < N; i++) add(OP_WR, A_DIN, b1[i], 4'hF, 2'b00, 0);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0000_0008);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h0C);
        add(OP_WR, A_CTRL, 32'h2, 4'hF, 2'b00, 0);
        add(OP_IDLE, 0, 40, 0, 0, 0);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h02);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0008_0000);
        for (int unsigned i = 1; i <= N; i++) add(OP_RD, A_DOUT, 0, 0, 2'b00, 32'(i));
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h08);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0);
        add(OP_WR, A_DIN, 32'd10, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd20, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd30, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd99, 4'h0, 2'b00, 0);
        add(OP_WR, A_CTRL, 32'h2, 4'hF, 2'b00, 0);
        add(OP_IDLE, 0, 5, 0, 0, 0);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h18);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0000_0003);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h08);
        add(OP_RD, 32'h14, 0, 0, 2'b10, 32'h0);
        add(OP_RD, A_CTRL, 0, 0, 2'b10, 32'h0);
        add(OP_WR, A_DOUT, 32'h5, 4'hF, 2'b10, 0);
        add(OP_RD, 32'h1C, 0, 0, 2'b10, 32'h0);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h08);
        add(OP_RD, A_DOUT, 0, 0, 2'b00, 32'h0);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h18);
        add(OP_WR, A_CTRL, 32'h1, 4'hF, 2'b00, 0);
        add(OP_IDLE, 0, 4, 0, 0, 0);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h08);
        add(OP_WR, A_DIN, 32'd40, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd10, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd80, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd20, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd70, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd30, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd60, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd50, 4'hF, 2'b00, 0);
        add(OP_WR, A_DIN, 32'd99, 4'hF, 2'b00, 0);
        add(OP_RD, A_COUNT, 0, 0, 2'b00, 32'h0000_0008);
        add(OP_RD, A_STATUS, 0, 0, 2'b00, 32'h1C);

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", 32'(s_awready), 0);
        chk("rst_arready", 32'(s_arready), 0);
        chk("rst_bvalid", 32'(s_bvalid), 0);
        chk("rst_rvalid", 32'(s_rvalid), 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_core_load_start", {30'b0, core_load, core_start}, 0);
        chk("rst_irq", 32'(irq), 0);
        chk("core_ascending", 32'(core_ascending), 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("core_rst_hold", 32'(core_rst), 1);
        @(negedge clk);
        chk("core_rst_release", 32'(core_rst), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_WR: begin
                    axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                    chk($sformatf("v%0d_wr_%02h_bresp", i, vecs[i].addr), 32'(r), 32'(vecs[i].resp));
                end
                OP_RD: begin
                    axi_read(vecs[i].addr, d, r);
                    chk($sformatf("v%0d_rd_%02h_rresp", i, vecs[i].addr), 32'(r), 32'(vecs[i].resp));
                    chk($sformatf("v%0d_rd_%02h_rdata", i, vecs[i].addr), d, vecs[i].exp);
                end
                default: repeat (vecs[i].data) @(posedge clk);
            endcase
        end
        chk("start_pulses_after_table", 32'(start_cnt), 1);
        axi_read(A_STATUS, d, r);
        chk("status_err_cleared", d, 32'h0C);

        // Interrupt-enabled batch using the eight staged values
        axi_write(A_CTRL, 32'h4, 4'hF, r);
        @(negedge clk);
        chk("irq_idle_enabled", 32'(irq), 0);
        axi_write(A_CTRL, 32'h6, 4'hF, r);
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("irq_done", 32'(irq), 1);
        read_sorted("irqbatch", exp2, 1'b1);

        // AW accepted three cycles ahead of W, bready held low for four cycles
        @(posedge clk); #1;
        s_bready = 1'b0; s_awvalid = 1'b1; s_awaddr = A_DIN;
        @(negedge clk);
        chk("split_awready", 32'(s_awready), 1);
        @(posedge clk); #1 s_awvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 s_wvalid = 1'b1; s_wdata = 32'h77; s_wstrb = 4'hF;
        @(negedge clk);
        chk("split_wready", 32'(s_wready), 1);
        chk("split_no_early_bvalid", 32'(s_bvalid), 0);
        @(posedge clk); #1 s_wvalid = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("split_bvalid_held%0d", k), {29'b0, s_bvalid, s_bresp}, 32'h4);
            chk($sformatf("split_awready_blocked%0d", k), 32'(s_awready), 0);
        end
        @(posedge clk); #1 s_bready = 1'b1;
        @(posedge clk); #1 s_bready = 1'b0;
        @(negedge clk);
        chk("split_bvalid_cleared", 32'(s_bvalid), 0);
        axi_read(A_COUNT, d, r);
        chk("split_single_write", d, 32'h1);
        axi_read(32'h14, d, r);
        chk("bad_off_rresp", 32'(r), 32'h2);
        chk("bad_off_rdata", d, 0);
        axi_write(A_CTRL, 32'h1, 4'hF, r);
        repeat (4) @(posedge clk);

        // Reset in the middle of a sort, then a fresh batch
        for (int unsigned i = 0; i < N; i++) axi_write(A_DIN, b3[i], 4'hF, r);
        axi_write(A_CTRL, 32'h2, 4'hF, r);
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (core_start) seen = 1;
        end
        if (!seen) timeout("wait_core_start");
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("midrst_ready", {30'b0, s_awready, s_arready}, 0);
        chk("midrst_valids", {30'b0, s_bvalid, s_rvalid}, 0);
        chk("midrst_resps", {28'b0, s_bresp, s_rresp}, 0);
        chk("midrst_core", {29'b0, core_rst, core_load, core_start}, 32'h4);
        chk("midrst_irq", 32'(irq), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_core_rst_hold", 32'(core_rst), 1);
        @(negedge clk);
        chk("midrst_core_rst_release", 32'(core_rst), 0);
        axi_read(A_COUNT, d, r);
        chk("midrst_count", d, 0);
        axi_read(A_STATUS, d, r);
        chk("midrst_status", d, 32'h08);
        for (int unsigned i = 0; i < N; i++) axi_write(A_DIN, b3[i], 4'hF, r);
        axi_write(A_CTRL, 32'h2, 4'hF, r);
        repeat (40) @(posedge clk);
        axi_read(A_STATUS, d, r);
        chk("rebatch_done", d, 32'h02);
        read_sorted("rebatch", exp3, 1'b0);
        axi_read(A_STATUS, d, r);
        chk("rebatch_idle", d, 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/axi_sort_periph.md
AXI_SORT_PERIPH -- requirements
Module: axi_sort_periph

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, element width (1..32).
REQ-002 SHALL have parameter LOG_INPUT_NUM, default 3, log2 of elements per sort batch N.
REQ-003 SHALL have parameter ASCENDING, default 1, forwarded on core_ascending output (1 = ascending).
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have AXI4-Lite slave ports: s_awvalid/s_awready/s_awaddr[31:0], s_wvalid/s_wready/s_wdata[31:0]/s_wstrb[3:0], s_bvalid/s_bready/s_bresp[1:0], s_arvalid/s_arready/s_araddr[31:0], s_rvalid/s_rready/s_rdata[31:0]/s_rresp[1:0].
REQ-007 SHALL have core ports: core_rst out 1; core_din out DATA_WIDTH; core_load out 1 (din valid strobe); core_start out 1 (one-cycle pulse); core_ascending out 1; core_dout in DATA_WIDTH; core_y_valid in 1.
REQ-008 SHALL have irq out 1, level interrupt.

Function
REQ-009 SHALL decode addr[4:2]: 0 CTRL(W), 1 DIN(W), 2 STATUS(R), 3 DOUT(R), 4 COUNT(R); other offsets, or writes to R / reads of W registers -> resp 2'b10 (SLVERR), rdata 0, no side effect.
REQ-010 SHALL accept AW and W independently, one outstanding write; write executes the cycle both are held; bvalid rises next cycle, holds until bready; no new AW/W accepted while bvalid high.
REQ-011 SHALL accept AR only when rvalid low; rdata/rresp registered, rvalid next cycle, held until rready.
REQ-012 SHALL treat a write with wstrb == 0 as OKAY with no effect; any nonzero wstrb writes the full register.
REQ-013 CTRL: bit0 soft_reset (self-clearing pulse), bit1 start (pulse), bit2 irq_en (stored); soft_reset wins over start in the same write.
REQ-014 DIN write SHALL push wdata[DATA_WIDTH-1:0] into input FIFO (depth N); if full or FSM not IDLE: drop, set sticky err, bresp OKAY.
REQ-015 DOUT read SHALL pop output FIFO (depth N), return zero-extended data; if empty: return 0, set err, rresp OKAY.
REQ-016 STATUS SHALL read {27'b0, err, out_empty, in_full, done, busy}; reading STATUS clears err (after capture).
REQ-017 COUNT SHALL read {out_count[15:0], in_count[15:0]}, counts LOG_INPUT_NUM+1 bits wide, zero-extended.
REQ-018 FSM states IDLE, LOAD, SORT, DRAIN, DONE; busy = state in {LOAD, SORT, DRAIN}.
REQ-019 IDLE->LOAD on start iff in_count == N and out_count == 0; otherwise start ignored, err set.
REQ-020 LOAD: one element per cycle, core_load=1, core_din=FIFO head, for exactly N cycles; then core_start pulses one cycle, ->SORT.
REQ-021 SORT->DRAIN on first cycle core_y_valid=1; each cycle with core_y_valid=1 in SORT/DRAIN pushes core_dout to output FIFO; after N pushes ->DONE.
REQ-022 core_y_valid while IDLE/LOAD/DONE SHALL be ignored.
REQ-023 DONE: done=1; ->IDLE when output FIFO becomes empty; done clears same edge.
REQ-024 irq = done & irq_en, registered-free combinational from state and irq_en.
REQ-025 soft_reset SHALL, next edge, flush both FIFOs, clear err/done, force IDLE, assert core_rst for 2 cycles; irq_en and pending AXI responses unaffected.
REQ-026 FIFO pointers wrap modulo N; full = count == N, empty = count == 0.

Reset
REQ-027 SHALL on rst=1 immediately: all valids/readies 0, resp 0, rdata 0, FIFOs empty, counts 0, err/done/irq_en 0, state IDLE, core_load/core_start 0, core_rst 1.
REQ-028 SHALL release core_rst one cycle after rst deasserts; rst mid-sort abandons batch, AXI transaction in flight dropped (no bvalid/rvalid).

Verification
REQ-029 N=8: write DIN 5,3,7,1,8,2,6,4, CTRL=0x2, model core returns sorted -> STATUS done=1, 8 DOUT reads give 1..8, then done=0, busy=0.
REQ-030 Write 3 DINs, CTRL=0x2 -> no core_start, STATUS err=1, COUNT=0x0000_0003; second STATUS read err=0.
REQ-031 9th DIN write with FIFO full -> bresp OKAY, in_count stays 8, err=1.
REQ-032 CTRL=0x4 then full batch -> irq rises with done, falls after 8th DOUT pop.
REQ-033 AW held 3 cycles before W, bready low 4 cycles -> single write, bvalid held stable; read 0x14 -> rresp 2'b10, rdata 0.
REQ-034 Assert rst during SORT -> all outputs at reset values that cycle; after release, new batch sorts correctly.
